// File: rtl/inst_fetch_pkg.sv
//------------------------------------------------------------------------------
// inst_fetch_pkg : shared encodings for the instruction-fetch block
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package inst_fetch_pkg;

  localparam int unsigned INST_ADDR_BUS_W = 32;
  localparam int unsigned INST_BUS_W      = 32;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_HOLD  = 2'd2
  } if_state_e;

endpackage : inst_fetch_pkg

`default_nettype wire

// File: rtl/inst_fetch_pc_gen.sv
//------------------------------------------------------------------------------
// fetch_pc_gen : PC register with +4 increment and word-aligned redirect load
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_pc_gen
  import inst_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = INST_ADDR_BUS_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Load wins over advance; the increment wraps silently at the top of the space.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i & ~ADDR_W'(3);
    end else if (advance_i) begin
      pc_d = pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule : fetch_pc_gen

`default_nettype wire

// File: rtl/inst_fetch.sv
//------------------------------------------------------------------------------
// inst_fetch : ROM requester with one-entry hold buffer feeding the IF/ID register
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = INST_ADDR_BUS_W,
  parameter int unsigned INST_W   = INST_BUS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic [INST_W-1:0] rom_inst_i,
  input  logic              rom_ready_i,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_valid_o
);

  if_state_e         state_q, state_d;
  logic [INST_W-1:0] hold_q, hold_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic              id_valid_q, id_valid_d;

  logic              pc_load;
  logic              pc_adv;
  logic [ADDR_W-1:0] pc;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;

  assign redirect        = flush_i | branch_flag_i;
  assign redirect_target = flush_i ? new_pc_i : branch_target_i;

  fetch_pc_gen #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (ADDR_W'(RESET_PC))
  ) u_pc_gen (
    .clk       (clk),
    .rst       (rst),
    .load_i    (pc_load),
    .target_i  (redirect_target),
    .advance_i (pc_adv),
    .pc_o      (pc)
  );

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    pc_load    = 1'b0;
    pc_adv     = 1'b0;

    if (state_q == IF_IDLE) begin
      state_d = IF_FETCH;
      pc_load = redirect;
    end else if (redirect) begin
      // Redirect overrides stall and discards any same-cycle ROM response.
      pc_load    = 1'b1;
      state_d    = IF_FETCH;
      hold_d     = '0;
      id_pc_d    = '0;
      id_inst_d  = '0;
      id_valid_d = 1'b0;
    end else begin
      case (state_q)
        IF_FETCH: begin
          if (rom_ready_i && !stall_i) begin
            id_pc_d    = pc;
            id_inst_d  = rom_inst_i;
            id_valid_d = 1'b1;
            pc_adv     = 1'b1;
          end else if (rom_ready_i) begin
            hold_d  = rom_inst_i;
            state_d = IF_HOLD;
          end else if (!stall_i) begin
            id_pc_d    = '0;
            id_inst_d  = '0;
            id_valid_d = 1'b0;
          end
        end
        IF_HOLD: begin
          if (!stall_i) begin
            id_pc_d    = pc;
            id_inst_d  = hold_q;
            id_valid_d = 1'b1;
            pc_adv     = 1'b1;
            state_d    = IF_FETCH;
          end
        end
        default: state_d = IF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IF_IDLE;
      hold_q     <= '0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign rom_ce_o   = (state_q == IF_FETCH) ? CHIP_ENABLE : CHIP_DISABLE;
  assign rom_addr_o = pc;
  assign id_pc_o    = id_pc_q;
  assign id_inst_o  = id_inst_q;
  assign id_valid_o = id_valid_q;

endmodule : inst_fetch

`default_nettype wire

// File: tb/tb_inst_fetch.sv
//------------------------------------------------------------------------------
// tb_inst_fetch : directed self-checking bench for inst_fetch
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic [31:0] rom_inst_i;
  logic        rom_ready_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;

  logic [31:0] mem [8];
  int          n_checks;
  int          n_errors;
  int          reads_of_8;
  int          reads_snap;

  inst_fetch #(
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (32),
    .INST_W   (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .rom_inst_i      (rom_inst_i),
    .rom_ready_i     (rom_ready_i),
    .rom_ce_o        (rom_ce_o),
    .rom_addr_o      (rom_addr_o),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .id_valid_o      (id_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Eight-word combinational ROM, aliased across the address space.
  assign rom_inst_i = mem[rom_addr_o[4:2]];

  always @(negedge clk) begin
    if (rom_ce_o && rom_ready_i && rom_addr_o == 32'h8) reads_of_8 = reads_of_8 + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_id(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                          input logic valid);
    check_eq({tag, ".pc"}, id_pc_o, pc);
    check_eq({tag, ".inst"}, id_inst_o, inst);
    check_eq({tag, ".valid"}, {31'd0, id_valid_o}, {31'd0, valid});
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    reads_of_8      = 0;
    reads_snap      = 0;
    mem[0] = 32'h0000_0013; mem[1] = 32'h0040_0093;
    mem[2] = 32'h0080_0113; mem[3] = 32'h00C0_0193;
    mem[4] = 32'h0100_0213; mem[5] = 32'h0140_0293;
    mem[6] = 32'h0180_0313; mem[7] = 32'h01C0_0393;
    rst             = 1'b1;
    stall_i         = 1'b0;
    branch_flag_i   = 1'b0;
    branch_target_i = 32'h0;
    flush_i         = 1'b0;
    new_pc_i        = 32'h0;
    rom_ready_i     = 1'b1;

    // Reset state
    tick();
    tick();
    check_id("reset", 32'h0, 32'h0, 1'b0);
    check_eq("reset.ce", {31'd0, rom_ce_o}, 32'd0);
    check_eq("reset.addr", rom_addr_o, 32'h0);
    rst = 1'b0;
    #1;
    check_eq("idle.ce", {31'd0, rom_ce_o}, 32'd0);

    // Test 1: streaming fetch, one word per clock after one idle cycle
    tick();
    check_eq("t1.ce", {31'd1 & 32'd0, rom_ce_o}, 32'd1);
    check_eq("t1.addr0", rom_addr_o, 32'h0);
    check_eq("t1.bubble", {31'd0, id_valid_o}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_id($sformatf("t1.w%0d", k), 32'(k * 4), mem[k], 1'b1);
    end
    check_eq("t1.addr_end", rom_addr_o, 32'h20);

    // Test 3: branch with misaligned target
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h0000_0013;
    tick();
    branch_flag_i = 1'b0;
    check_eq("t3.addr", rom_addr_o, 32'h10);
    check_id("t3.bubble", 32'h0, 32'h0, 1'b0);
    tick();
    check_id("t3.first", 32'h10, mem[4], 1'b1);

    // Test 2: stall while fetching addr 8
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h0;
    tick();
    branch_flag_i = 1'b0;
    tick();
    check_id("t2.w0", 32'h0, mem[0], 1'b1);
    tick();
    check_id("t2.w1", 32'h4, mem[1], 1'b1);
    check_eq("t2.addr8", rom_addr_o, 32'h8);
    reads_snap = reads_of_8;
    stall_i    = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      check_id($sformatf("t2.frz%0d", s), 32'h4, mem[1], 1'b1);
      check_eq($sformatf("t2.hold_ce%0d", s), {31'd0, rom_ce_o}, 32'd0);
      check_eq($sformatf("t2.hold_addr%0d", s), rom_addr_o, 32'h8);
    end
    stall_i = 1'b0;
    tick();
    check_id("t2.rel", 32'h8, mem[2], 1'b1);
    check_eq("t2.addr_next", rom_addr_o, 32'hC);
    check_eq("t2.reads8", 32'(reads_of_8 - reads_snap), 32'd1);

    // Test 4: flush and branch together while in HOLD
    stall_i = 1'b1;
    tick();
    check_eq("t4.in_hold", {31'd0, rom_ce_o}, 32'd0);
    flush_i         = 1'b1;
    branch_flag_i   = 1'b1;
    new_pc_i        = 32'h40;
    branch_target_i = 32'h20;
    tick();
    flush_i       = 1'b0;
    branch_flag_i = 1'b0;
    check_eq("t4.addr", rom_addr_o, 32'h40);
    check_id("t4.bubble", 32'h0, 32'h0, 1'b0);
    check_eq("t4.ce", {31'd0, rom_ce_o}, 32'd1);
    stall_i = 1'b0;
    tick();
    check_id("t4.after", 32'h40, mem[0], 1'b1);

    // Test 5: ROM not ready for two cycles at addr 4
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h4;
    tick();
    branch_flag_i = 1'b0;
    rom_ready_i   = 1'b0;
    for (int w = 0; w < 2; w++) begin
      tick();
      check_eq($sformatf("t5.addr%0d", w), rom_addr_o, 32'h4);
      check_id($sformatf("t5.bub%0d", w), 32'h0, 32'h0, 1'b0);
    end
    rom_ready_i = 1'b1;
    tick();
    check_id("t5.deliver", 32'h4, mem[1], 1'b1);

    // Test 6: wrap at top of address space, then async reset mid-HOLD
    branch_flag_i   = 1'b1;
    branch_target_i = 32'hFFFF_FFFC;
    tick();
    branch_flag_i = 1'b0;
    check_eq("t6.addr_top", rom_addr_o, 32'hFFFF_FFFC);
    tick();
    check_id("t6.top", 32'hFFFF_FFFC, mem[7], 1'b1);
    check_eq("t6.wrap", rom_addr_o, 32'h0);
    stall_i = 1'b1;
    tick();
    check_eq("t6.hold_ce", {31'd0, rom_ce_o}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_id("t6.rst", 32'h0, 32'h0, 1'b0);
    check_eq("t6.rst_ce", {31'd0, rom_ce_o}, 32'd0);
    check_eq("t6.rst_addr", rom_addr_o, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_inst_fetch

`default_nettype wire
